// File: rtl/irrigation_pkg.sv
// Shared state encoding and default durations for the irrigation controller.
package irrigation_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_SPRINKLE = 3'd2,
        ST_DRIP     = 3'd3,
        ST_ALARM    = 3'd4
    } state_e;

    localparam int DEF_SPRINKLE_TICKS = 4;
    localparam int DEF_DRIP_TICKS     = 6;
    localparam int DEF_FILL_TIMEOUT   = 16;
    localparam int DEF_CNT_W          = 5;

    // Lane order of the divider inputs through the tick conditioners.
    localparam int NUM_TICK  = 4;
    localparam int TK_SPRINK = 0;
    localparam int TK_DRIP   = 1;
    localparam int TK_FILL   = 2;
    localparam int TK_1HZ    = 3;

endpackage

// File: rtl/irrigation_controller_tick_sync.sv
// Brings a divider ripple-clock into the system domain and turns each rise into a one-cycle tick.
module tick_sync (
    input  logic clk_896hz,
    input  logic clear_n,
    input  logic async_in,
    output logic tick,
    output logic level
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_896hz or negedge clear_n) begin
        if (!clear_n) sync_q <= '0;
        else          sync_q <= {sync_q[1:0], async_in};
    end

    // sync_q[1] is the metastability-safe level; sync_q[2] is its one-cycle history.
    assign tick  = sync_q[1] & ~sync_q[2];
    assign level = sync_q[1];

endmodule

// File: rtl/irrigation_controller.sv
// Irrigation sequencer: tank fill, sprinkler and drip runs timed by divider ticks, with fill-failure alarm.
module irrigation_controller
    import irrigation_pkg::*;
#(
    parameter int SPRINKLE_TICKS = DEF_SPRINKLE_TICKS,
    parameter int DRIP_TICKS     = DEF_DRIP_TICKS,
    parameter int FILL_TIMEOUT   = DEF_FILL_TIMEOUT,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic               clk_896hz,
    input  logic               clear_n,
    input  logic               sprinkler_clk,
    input  logic               drip_clk,
    input  logic               fill_clk,
    input  logic               clk_1hz,
    input  logic               enable,
    input  logic               dry,
    input  logic               mode,
    input  logic               lvl_low,
    input  logic               lvl_high,
    output logic               valve_fill,
    output logic               valve_sprinkler,
    output logic               valve_drip,
    output logic               alarm,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   count
);

    logic [NUM_TICK-1:0] div_in;
    logic [NUM_TICK-1:0] tick;
    logic [NUM_TICK-1:0] level;

    assign div_in[TK_SPRINK] = sprinkler_clk;
    assign div_in[TK_DRIP]   = drip_clk;
    assign div_in[TK_FILL]   = fill_clk;
    assign div_in[TK_1HZ]    = clk_1hz;

    for (genvar i = 0; i < NUM_TICK; i++) begin : g_tick
        tick_sync u_tick_sync (
            .clk_896hz (clk_896hz),
            .clear_n   (clear_n),
            .async_in  (div_in[i]),
            .tick      (tick[i]),
            .level     (level[i])
        );
    end

    // The 1 Hz lane is only used as a level, the others only as ticks.
    logic unused_lanes;
    assign unused_lanes = ^{tick[TK_1HZ], level[TK_FILL:TK_SPRINK]};

    localparam logic [CNT_W-1:0] SPR_LOAD  = CNT_W'(SPRINKLE_TICKS);
    localparam logic [CNT_W-1:0] DRIP_LOAD = CNT_W'(DRIP_TICKS);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             run_tick;

    always_ff @(posedge clk_896hz or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign run_tick = (state_q == ST_SPRINKLE) ? tick[TK_SPRINK] : tick[TK_DRIP];

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (!enable) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (dry) begin
                        if (!lvl_low) begin
                            state_d = ST_FILL;
                            count_d = '0;
                        end else if (!mode) begin
                            state_d = ST_SPRINKLE;
                            count_d = SPR_LOAD;
                        end else begin
                            state_d = ST_DRIP;
                            count_d = DRIP_LOAD;
                        end
                    end
                end
                ST_FILL: begin
                    // A full tank wins over a timeout tick landing on the same edge.
                    if (lvl_high) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end else if (tick[TK_FILL]) begin
                        if (count_q >= FILL_LAST) begin
                            state_d = ST_ALARM;
                            count_d = '0;
                        end else begin
                            count_d = count_q + CNT_ONE;
                        end
                    end
                end
                ST_SPRINKLE, ST_DRIP: begin
                    // Running out of water restarts the run from scratch after the refill.
                    if (!lvl_low) begin
                        state_d = ST_FILL;
                        count_d = '0;
                    end else if (!dry) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end else if (run_tick) begin
                        if (count_q <= CNT_ONE) begin
                            state_d = ST_IDLE;
                            count_d = '0;
                        end else begin
                            count_d = count_q - CNT_ONE;
                        end
                    end
                end
                ST_ALARM: begin
                    state_d = ST_ALARM;
                    count_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign valve_fill      = (state_q == ST_FILL);
    assign valve_sprinkler = (state_q == ST_SPRINKLE);
    assign valve_drip      = (state_q == ST_DRIP);
    assign alarm           = (state_q == ST_ALARM) & level[TK_1HZ];
    assign state           = state_q;
    assign count           = count_q;

endmodule

// File: tb/tb_irrigation_controller.sv
// Scoreboard bench: stimulus queues every expected {state,count} change, a monitor pops on each change.
module tb_irrigation_controller;

    logic       clk = 1'b0;
    logic       clear_n = 1'b1;
    logic       sprinkler_clk = 1'b0, drip_clk = 1'b0, fill_clk = 1'b0, clk_1hz = 1'b0;
    logic       enable = 1'b0, dry = 1'b0, mode = 1'b0, lvl_low = 1'b0, lvl_high = 1'b0;
    logic       valve_fill, valve_sprinkler, valve_drip, alarm;
    logic [2:0] state;
    logic [4:0] count;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    irrigation_controller dut (
        .clk_896hz       (clk),
        .clear_n         (clear_n),
        .sprinkler_clk   (sprinkler_clk),
        .drip_clk        (drip_clk),
        .fill_clk        (fill_clk),
        .clk_1hz         (clk_1hz),
        .enable          (enable),
        .dry             (dry),
        .mode            (mode),
        .lvl_low         (lvl_low),
        .lvl_high        (lvl_high),
        .valve_fill      (valve_fill),
        .valve_sprinkler (valve_sprinkler),
        .valve_drip      (valve_drip),
        .alarm           (alarm),
        .state           (state),
        .count           (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void push(input logic [2:0] s, input logic [4:0] c);
        exp_q.push_back({s, c});
    endfunction

    // Monitor: every observed change of {state,count} must match the next queued expectation.
    initial begin
        logic [7:0] prev, cur, e;
        prev = 8'h00;
        forever begin
            @(negedge clk);
            cur = {state, count};
            if ((32'(valve_fill) + 32'(valve_sprinkler) + 32'(valve_drip)) > 1) begin
                n_errors++;
                $display("FAIL onehot_valves: fill=%0b spr=%0b drip=%0b", valve_fill, valve_sprinkler, valve_drip);
            end
            if (cur !== prev) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_change: got state=%0d count=%0d, nothing expected", cur[7:5], cur[4:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        n_errors++;
                        $display("FAIL transition: got state=%0d count=%0d expected state=%0d count=%0d",
                                 cur[7:5], cur[4:0], e[7:5], e[4:0]);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic pulse(input int which);
        @(negedge clk);
        case (which)
            0: sprinkler_clk = 1'b1;
            1: drip_clk      = 1'b1;
            2: fill_clk      = 1'b1;
            default: clk_1hz = 1'b1;
        endcase
        repeat (4) @(negedge clk);
        sprinkler_clk = 1'b0; drip_clk = 1'b0; fill_clk = 1'b0; clk_1hz = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #1 clear_n = 1'b0;
        #2;
        chk("reset_state", state, 0);
        chk("reset_count", count, 0);
        chk("reset_valves", {valve_fill, valve_sprinkler, valve_drip}, 0);
        chk("reset_alarm", alarm, 0);
        @(negedge clk);
        clear_n = 1'b1;
        dry = 1'b1; lvl_low = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_when_disabled", state, 0);

        // Sprinkle run, drip rises ignored, then IDLE re-enters immediately.
        push(2, 4);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("sprinkle_valve", valve_sprinkler, 1);
        pulse(1);
        push(2, 3); pulse(0);
        push(2, 2); pulse(0);
        pulse(1);
        push(2, 1); pulse(0);
        push(0, 0); push(2, 4); pulse(0);
        drain("sprinkle");

        // Asynchronous reset in the middle of the run.
        @(negedge clk);
        #2;
        push(0, 0);
        clear_n = 1'b0;
        #1;
        chk("async_rst_valve", valve_sprinkler, 0);
        chk("async_rst_state", state, 0);
        chk("async_rst_count", count, 0);
        enable = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", state, 0);
        drain("reset");

        // Fill, then drip after the tank is full; dry falls mid-drip.
        mode = 1'b1; lvl_low = 1'b0; lvl_high = 1'b0;
        push(1, 0);
        enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            push(1, 5'(i)); pulse(2);
        end
        chk("fill_valve", valve_fill, 1);
        push(0, 0); push(3, 6);
        lvl_high = 1'b1; lvl_low = 1'b1;
        repeat (3) @(negedge clk);
        chk("drip_valve", valve_drip, 1);
        pulse(0);
        for (int i = 5; i >= 3; i--) begin
            push(3, 5'(i)); pulse(1);
        end
        push(0, 0);
        dry = 1'b0;
        repeat (3) @(negedge clk);
        drain("fill_drip");

        // Water runs out mid-sprinkle: refill, then the run restarts with a full count.
        lvl_high = 1'b0; mode = 1'b0;
        push(2, 4);
        dry = 1'b1;
        repeat (2) @(negedge clk);
        push(2, 3); pulse(0);
        push(1, 0);
        lvl_low = 1'b0;
        repeat (3) @(negedge clk);
        push(0, 0); push(2, 4);
        lvl_low = 1'b1; lvl_high = 1'b1;
        repeat (3) @(negedge clk);
        push(0, 0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        drain("refill");

        // Fill timeout into ALARM; alarm blinks with clk_1hz and ignores sensors.
        lvl_high = 1'b0; lvl_low = 1'b0;
        push(1, 0);
        enable = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            push(1, 5'(i)); pulse(2);
        end
        push(4, 0); pulse(2);
        chk("alarm_valve_fill", valve_fill, 0);
        chk("alarm_state", state, 4);
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            clk_1hz = 1'b1;
            repeat (4) @(negedge clk);
            chk("alarm_blink_hi", alarm, 1);
            clk_1hz = 1'b0;
            lvl_high = ~lvl_high; dry = ~dry; lvl_low = ~lvl_low;
            repeat (4) @(negedge clk);
            chk("alarm_blink_lo", alarm, 0);
        end
        chk("alarm_sticky", state, 4);
        push(0, 0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("alarm_cleared", alarm, 0);
        drain("timeout");

        // Full tank on the same edge as the 16th fill tick.
        dry = 1'b1; lvl_low = 1'b0; lvl_high = 1'b0;
        push(1, 0);
        enable = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            push(1, 5'(i)); pulse(2);
        end
        push(0, 0);
        @(negedge clk);
        fill_clk = 1'b1;
        repeat (2) @(negedge clk);
        lvl_high = 1'b1; dry = 1'b0;
        repeat (3) @(negedge clk);
        fill_clk = 1'b0;
        repeat (3) @(negedge clk);
        chk("coincide_fill_idle", state, 0);
        drain("coincide_fill");

        // enable drops on the same edge as a sprinkler tick.
        lvl_high = 1'b0; lvl_low = 1'b1; mode = 1'b0;
        push(2, 4);
        dry = 1'b1;
        repeat (3) @(negedge clk);
        push(0, 0);
        @(negedge clk);
        sprinkler_clk = 1'b1;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        sprinkler_clk = 1'b0;
        repeat (3) @(negedge clk);
        chk("coincide_enable_idle", state, 0);
        drain("coincide_enable");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/irrigation_controller.md
Name: irrigation_controller

Overview:
- Consumer of the frequency divider's tick outputs (sprinkler_clk, drip_clk, fill_clk, clk_1hz).
- Runs the irrigation sequence: tank filling, sprinkler watering and drip watering, driven by soil and tank sensors.
- Converts the divider's ripple-clock outputs into synchronous one-cycle enables in the system clock domain.
- Drives the valve and alarm outputs.

Parameters:
- SPRINKLE_TICKS, 4: sprinkler_clk periods per sprinkler run.
- DRIP_TICKS, 6: drip_clk periods per drip run.
- FILL_TIMEOUT, 16: fill_clk periods before a fill is declared failed.
- CNT_W, 5: width of the duration/timeout counter; must hold max(SPRINKLE_TICKS, DRIP_TICKS, FILL_TIMEOUT).

Ports:
- clk_896hz, in, 1: system clock, the same source that feeds the divider.
- clear_n, in, 1: reset, asynchronous, active-low.
- sprinkler_clk, in, 1: divider output, 7/15 Hz.
- drip_clk, in, 1: divider output, 7/30 Hz.
- fill_clk, in, 1: divider output, 0.8 Hz.
- clk_1hz, in, 1: divider output, 1 Hz, used for alarm blink.
- enable, in, 1: master switch. 0 forces IDLE.
- dry, in, 1: soil sensor, 1 = soil dry.
- mode, in, 1: watering mode, 0 = sprinkler, 1 = drip.
- lvl_low, in, 1: 1 = water above the tank low mark.
- lvl_high, in, 1: 1 = tank full.
- valve_fill, out, 1: tank inlet valve.
- valve_sprinkler, out, 1: sprinkler valve.
- valve_drip, out, 1: drip valve.
- alarm, out, 1: fill-failure indicator, blinking.
- state, out, 3: current FSM state, for display.
- count, out, CNT_W: ticks remaining in SPRINKLE/DRIP, ticks elapsed in FILL, 0 otherwise.

Behaviour:
- Reset (clear_n=0, asynchronous):
  - state=IDLE (0); count=0; all valves 0; alarm=0.
  - All synchroniser and edge registers cleared.
  - Release is synchronous to the next clk_896hz edge.
- Tick conditioning:
  - Each divider input passes through a 2-FF synchroniser, then rising-edge detection (sync2 & ~sync3).
  - Each input rise produces exactly one tick pulse, one cycle wide, 2-3 clk cycles after the rise.
  - A falling edge produces no pulse.
- State encoding: IDLE=0, FILL=1, SPRINKLE=2, DRIP=3, ALARM=4.
- Outputs are Moore outputs decoded from the state register:
  - valve_fill=1 only in FILL.
  - valve_sprinkler=1 only in SPRINKLE.
  - valve_drip=1 only in DRIP.
  - At most one valve is high in any cycle.
- Global rule: enable=0 in any state -> IDLE on the next edge, count=0. This overrides every other condition.
- IDLE:
  - enable & dry & !lvl_low -> FILL, count=0.
  - enable & dry & lvl_low & !mode -> SPRINKLE, count=SPRINKLE_TICKS.
  - enable & dry & lvl_low & mode -> DRIP, count=DRIP_TICKS.
  - Otherwise stay in IDLE.
- FILL, priority order:
  1. lvl_high -> IDLE, count=0; IDLE re-evaluates on the following cycle.
  2. fill tick with count==FILL_TIMEOUT-1 -> ALARM, count=0.
  3. fill tick -> count+1.
  - lvl_high takes priority over a coincident timeout tick.
- SPRINKLE / DRIP, priority order:
  1. !lvl_low -> FILL, count=0; the watering run restarts in full after refill.
  2. !dry -> IDLE, count=0.
  3. Own tick (sprinkler tick / drip tick) with count==1 -> IDLE, count=0.
  4. Own tick -> count-1.
  - Ticks from the other sources are ignored.
- ALARM:
  - alarm follows the synchronised clk_1hz level, giving a 1 Hz blink.
  - Leaves only via enable=0 or reset.
  - Sensor changes are ignored.
- count never wraps:
  - No decrement below 1.
  - No increment past FILL_TIMEOUT-1.
- Reset asserted mid-operation closes all valves immediately (asynchronous).

Decomposition:
- Package irrigation_pkg:
  - State encoding constants (IDLE, FILL, SPRINKLE, DRIP, ALARM).
  - State width of 3.
  - Default tick counts for the three durations.
- Sub-module tick_sync:
  - Function: 2-FF synchroniser plus rising-edge pulse.
  - Ports: clk_896hz, clear_n, async_in, tick.
  - Instantiated 4 times.
- FSM and counter live in irrigation_controller.

Test Plan:
1. Reset: drive clear_n=0 mid-SPRINKLE -> valve_sprinkler=0, state=0, count=0 in the same cycle without a clock edge; after release, state stays 0 while enable=0.
2. Sprinkle run: enable=1, dry=1, lvl_low=1, mode=0 -> state=2, count=4; after 4 sprinkler_clk rises -> count 4,3,2,1 then state=0; exactly 4 decrements; drip_clk rises are ignored.
3. Fill then drip: lvl_low=0, mode=1, dry=1 -> state=1; 3 fill_clk rises -> count=3; set lvl_high=1, lvl_low=1 -> IDLE, then DRIP with count=6.
4. Fill timeout: lvl_high held 0 -> after 16 fill_clk rises, state=4, valve_fill=0, alarm tracks clk_1hz for 3 periods; sensor changes have no effect; enable=0 -> state=0, alarm=0.
5. Coincident events:
   - In FILL, lvl_high=1 in the same cycle as the 16th fill tick -> IDLE, not ALARM.
   - In SPRINKLE, enable=0 together with a sprinkler tick -> IDLE.
6. Mid-run aborts:
   - dry falls in DRIP with count=3 -> IDLE next edge.
   - lvl_low falls in SPRINKLE -> FILL, count=0; after refill, SPRINKLE reloads count=4.
   - Assertion that at most one valve is high holds throughout.
